// File: rtl/gauss_5x5_filter_pkg.sv
// Shared constants and state type for the
// 5x5 binomial filter.
package gauss_5x5_pkg;

  localparam int LATENCY = 3;
  localparam int ROUND   = 128;
  localparam int SHIFT   = 8;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    BLANK  = 2'd1,
    LINE   = 2'd2
  } state_t;

endpackage

// File: rtl/gauss_5x5_filter_if.sv
// Window-in / pixel-out bundle between the
// window generator, the filter and its consumer.
interface gauss_5x5_filter_if #(
  parameter int DSIZE = 16
);

  logic               invs;
  logic               inde;
  logic [25*DSIZE-1:0] inwin;
  logic               outvs;
  logic               outde;
  logic [DSIZE-1:0]   outdata;
  logic               line_err;

  modport master (
    output invs, inde, inwin,
    input  outvs, outde, outdata, line_err
  );

  modport slave (
    input  invs, inde, inwin,
    output outvs, outde, outdata, line_err
  );

endinterface

// File: rtl/gauss_5x5_filter_5tap.sv
// Registered 1-4-6-4-1 tap sum, built from
// shifts and adds.
module gauss_5tap #(
  parameter int IW = 16
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [IW-1:0] i_a,
  input  logic [IW-1:0] i_b,
  input  logic [IW-1:0] i_c,
  input  logic [IW-1:0] i_d,
  input  logic [IW-1:0] i_e,
  output logic [IW+3:0] o_y
);

  localparam int OW = IW + 4;

  logic [OW-1:0] w_a;
  logic [OW-1:0] w_b;
  logic [OW-1:0] w_c;
  logic [OW-1:0] w_d;
  logic [OW-1:0] w_e;
  logic [OW-1:0] w_sum;
  logic [OW-1:0] r_y;

  assign w_a = OW'(i_a);
  assign w_b = OW'(i_b);
  assign w_c = OW'(i_c);
  assign w_d = OW'(i_d);
  assign w_e = OW'(i_e);

  assign w_sum = w_a
               + (w_b << 2)
               + (w_c << 2)
               + (w_c << 1)
               + (w_d << 2)
               + w_e;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      r_y <= w_sum;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/gauss_5x5_filter.sv
// Separable 5x5 binomial filter with border
// pass-through and per-frame line-length check.
module gauss_5x5_filter #(
  parameter int DSIZE        = 16,
  parameter int VIDEO_WIDTH  = 1920,
  parameter int VIDEO_HEIGHT = 1080
) (
  input logic clock,
  input logic rst_n,
  gauss_5x5_filter_if.slave bus
);

  import gauss_5x5_pkg::*;

  localparam int CW = $clog2(VIDEO_WIDTH + 1);
  localparam int RW = $clog2(VIDEO_HEIGHT);
  localparam int VW = DSIZE + 4;
  localparam int HW = DSIZE + 8;

  localparam logic [CW-1:0] COL_LEN = CW'(VIDEO_WIDTH);
  localparam logic [CW-1:0] COL_HI  = CW'(VIDEO_WIDTH - 3);
  localparam logic [CW-1:0] COL_SAT = '1;
  localparam logic [RW-1:0] ROW_HI  = RW'(VIDEO_HEIGHT - 3);
  localparam logic [RW-1:0] ROW_MAX = RW'(VIDEO_HEIGHT - 1);

  state_t r_state;
  state_t w_next;

  logic          r_vs_d;
  logic          r_de_d;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_err;

  logic          w_vs_rise;
  logic          w_de_rise;
  logic          w_de_fall;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_unsync;
  logic          w_err_set;
  logic          w_border;

  logic             r_b1, r_b2;
  logic [DSIZE-1:0] r_c1, r_c2;
  logic             r_de1, r_de2, r_de3;
  logic             r_vs1, r_vs2, r_vs3;
  logic [DSIZE-1:0] r_out;

  logic [VW-1:0]    w_v [5];
  logic [HW-1:0]    w_h;
  logic [DSIZE-1:0] w_filt;
  logic [DSIZE-1:0] w_ctr;

  assign w_vs_rise = bus.invs & ~r_vs_d;
  assign w_de_rise = bus.inde & ~r_de_d;
  assign w_de_fall = ~bus.inde & r_de_d;

  assign w_col = w_de_rise ? '0 : r_col;
  assign w_row = w_vs_rise ? '0 : r_row;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= UNSYNC;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_vs_rise) begin
      w_next = w_de_rise ? LINE : BLANK;
    end else begin
      unique case (r_state)
        BLANK:   if (w_de_rise) w_next = LINE;
        LINE:    if (w_de_fall) w_next = BLANK;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_unsync  = (r_state == UNSYNC);
    w_err_set = !w_unsync && w_de_fall
             && (r_col != COL_LEN);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_col  <= '0;
      r_row  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vs_d <= bus.invs;
      r_de_d <= bus.inde;
      if (bus.inde) begin
        r_col <= (w_col == COL_SAT) ?
                 w_col : w_col + CW'(1);
      end
      if (w_vs_rise) begin
        r_row <= '0;
      end else if (w_de_fall && r_row != ROW_MAX) begin
        r_row <= r_row + RW'(1);
      end
      if (w_vs_rise) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Until the first vsync the row is unknown,
  // so every pixel is handled as border.
  assign w_border = w_unsync
                  | (w_col < CW'(2))
                  | (w_col > COL_HI)
                  | (w_row < RW'(2))
                  | (w_row > ROW_HI);

  assign w_ctr = bus.inwin[12*DSIZE +: DSIZE];

  for (genvar c = 0; c < 5; c++) begin : g_vert
    gauss_5tap #(.IW(DSIZE)) u_v (
      .clock (clock),
      .rst_n (rst_n),
      .i_a   (bus.inwin[(0*5+c)*DSIZE +: DSIZE]),
      .i_b   (bus.inwin[(1*5+c)*DSIZE +: DSIZE]),
      .i_c   (bus.inwin[(2*5+c)*DSIZE +: DSIZE]),
      .i_d   (bus.inwin[(3*5+c)*DSIZE +: DSIZE]),
      .i_e   (bus.inwin[(4*5+c)*DSIZE +: DSIZE]),
      .o_y   (w_v[c])
    );
  end

  gauss_5tap #(.IW(VW)) u_h (
    .clock (clock),
    .rst_n (rst_n),
    .i_a   (w_v[0]),
    .i_b   (w_v[1]),
    .i_c   (w_v[2]),
    .i_d   (w_v[3]),
    .i_e   (w_v[4]),
    .o_y   (w_h)
  );

  assign w_filt = DSIZE'((w_h + HW'(ROUND)) >> SHIFT);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_b1  <= 1'b0;
      r_b2  <= 1'b0;
      r_c1  <= '0;
      r_c2  <= '0;
      r_de1 <= 1'b0;
      r_de2 <= 1'b0;
      r_de3 <= 1'b0;
      r_vs1 <= 1'b0;
      r_vs2 <= 1'b0;
      r_vs3 <= 1'b0;
      r_out <= '0;
    end else begin
      r_b1  <= w_border;
      r_b2  <= r_b1;
      r_c1  <= w_ctr;
      r_c2  <= r_c1;
      r_de1 <= bus.inde;
      r_de2 <= r_de1;
      r_de3 <= r_de2;
      r_vs1 <= bus.invs;
      r_vs2 <= r_vs1;
      r_vs3 <= r_vs2;
      r_out <= r_b2 ? r_c2 : w_filt;
    end
  end

  assign bus.outvs    = r_vs3;
  assign bus.outde    = r_de3;
  assign bus.outdata  = r_out;
  assign bus.line_err = r_err;

endmodule

// File: tb/tb_gauss_5x5_filter.sv
// Directed bench for gauss_5x5_filter: vector
// table on interior pixels plus frame sequences.
module tb_gauss_5x5_filter;

  import gauss_5x5_pkg::*;

  localparam int D   = 16;
  localparam int W   = 1920;
  localparam int H   = 12;
  localparam int NV  = 8;
  localparam int LAT = LATENCY;
  localparam int VR  = 5;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  always #5 clock = ~clock;

  gauss_5x5_filter_if #(.DSIZE(D)) bus ();

  gauss_5x5_filter #(
    .DSIZE        (D),
    .VIDEO_WIDTH  (W),
    .VIDEO_HEIGHT (H)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      nm;
    logic [D-1:0] c;
    logic [D-1:0] o;
    logic [D-1:0] exp;
  } vec_t;

  vec_t vt [NV];

  int checks   = 0;
  int failures = 0;

  logic [D-1:0] line_c [W];
  logic [D-1:0] line_o [W];
  logic [D-1:0] cap    [W];
  int ncap;
  int bad_de;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  function automatic logic [25*D-1:0] mk_win(
    input logic [D-1:0] c,
    input logic [D-1:0] o
  );
    logic [25*D-1:0] w;
    w = '0;
    for (int i = 0; i < 25; i++) begin
      w[i*D +: D] = (i == 12) ? c : o;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.inde  = 1'b0;
    bus.inwin = '0;
    repeat (n) tick();
  endtask

  task automatic fill_line(input logic [D-1:0] c,
                           input logic [D-1:0] o);
    for (int i = 0; i < W; i++) begin
      line_c[i] = c;
      line_o[i] = o;
    end
  endtask

  task automatic run_line(input int len);
    logic exp_de;
    ncap   = 0;
    bad_de = 0;
    for (int t = 0; t < len + LAT + 1; t++) begin
      if (t < len) begin
        bus.inde  = 1'b1;
        bus.inwin = mk_win(line_c[t], line_o[t]);
      end else begin
        bus.inde  = 1'b0;
        bus.inwin = '0;
      end
      tick();
      exp_de = (t >= LAT - 1) && (t < len + LAT - 1);
      if (bus.outde !== exp_de) bad_de++;
      if (bus.outde === 1'b1) begin
        if (ncap < W) cap[ncap] = bus.outdata;
        ncap++;
      end
    end
  endtask

  function automatic int exp_frame(input int r,
                                   input int c);
    if (c < 2 || c > W - 3 || r < 2 || r > H - 3)
      return 7;
    return 1;
  endfunction

  task automatic count_pass(input string nm);
    int nbad;
    nbad = 0;
    for (int i = 0; i < W; i++)
      if (cap[i] != 16'd7) nbad++;
    chk(nm, nbad, 0);
  endtask

  task automatic short_line_err();
    for (int t = 0; t < W - 1; t++) begin
      bus.inde  = 1'b1;
      bus.inwin = mk_win(16'd7, 16'd0);
      tick();
    end
    bus.inde  = 1'b0;
    bus.inwin = '0;
  endtask

  initial begin
    int nbad;
    bus.invs  = 1'b0;
    bus.inde  = 1'b0;
    bus.inwin = '0;

    vt[0] = '{"const100",   16'd100,   16'd100,   16'd100};
    vt[1] = '{"imp256",     16'd256,   16'd0,     16'd36};
    vt[2] = '{"imp1_round", 16'd1,     16'd0,     16'd0};
    vt[3] = '{"all_max",    16'hFFFF,  16'hFFFF,  16'hFFFF};
    vt[4] = '{"imp7",       16'd7,     16'd0,     16'd1};
    vt[5] = '{"imp1000",    16'd1000,  16'd0,     16'd141};
    vt[6] = '{"ring10",     16'd0,     16'd10,    16'd9};
    vt[7] = '{"c255_o1",    16'd255,   16'd1,     16'd37};

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_outvs",    bus.outvs,    0);
    chk("rst_outde",    bus.outde,    0);
    chk("rst_outdata",  bus.outdata,  0);
    chk("rst_line_err", bus.line_err, 0);
    rst_n = 1'b1;
    idle(4);

    fill_line(16'd7, 16'd0);
    run_line(W - 1);
    chk("unsync_len", ncap, W - 1);
    chk("unsync_de", bad_de, 0);
    nbad = 0;
    for (int i = 0; i < W - 1; i++)
      if (cap[i] != 16'd7) nbad++;
    chk("unsync_pass", nbad, 0);
    idle(4);
    chk("unsync_no_err", bus.line_err, 0);

    bus.invs = 1'b1;
    repeat (4) tick();
    bus.invs = 1'b0;
    idle(4);
    chk("vs_err_low", bus.line_err, 0);

    for (int r = 0; r < H; r++) begin
      fill_line(16'd7, 16'd0);
      if (r == VR) begin
        for (int i = 0; i < NV; i++) begin
          line_c[2+i] = vt[i].c;
          line_o[2+i] = vt[i].o;
        end
      end
      run_line(W);
      chk($sformatf("frame_de_row%0d", r),
          bad_de + ((ncap != W) ? 1 : 0), 0);
      nbad = 0;
      for (int c = 0; c < W; c++) begin
        if (r == VR && c >= 2 && c < 2 + NV)
          continue;
        if (int'(cap[c]) != exp_frame(r, c))
          nbad++;
      end
      chk($sformatf("frame_row%0d", r), nbad, 0);
      if (r == VR) begin
        for (int i = 0; i < NV; i++)
          chk(vt[i].nm, cap[2+i], vt[i].exp);
      end
      if (r == 2) begin
        chk("r2_col1",    cap[1],     7);
        chk("r2_col2",    cap[2],     1);
        chk("r2_col1917", cap[W-3],   1);
        chk("r2_col1918", cap[W-2],   7);
        chk("r2_col1919", cap[W-1],   7);
      end
      idle(6);
    end
    chk("frame_no_err", bus.line_err, 0);

    short_line_err();
    chk("err_before_fall", bus.line_err, 0);
    tick();
    chk("err_set", bus.line_err, 1);
    repeat (20) tick();
    chk("err_held", bus.line_err, 1);
    bus.invs = 1'b1;
    chk("err_before_vs", bus.line_err, 1);
    tick();
    chk("err_cleared", bus.line_err, 0);
    repeat (3) tick();
    bus.invs = 1'b0;
    idle(4);

    fill_line(16'd7, 16'd0);
    run_line(W - 1);
    idle(3);
    chk("err_set_again", bus.line_err, 1);

    for (int t = 0; t < 100; t++) begin
      bus.inde  = 1'b1;
      bus.inwin = mk_win(16'd7, 16'd0);
      tick();
    end
    chk("pre_rst_de",   bus.outde,   1);
    chk("pre_rst_data", bus.outdata, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outde",    bus.outde,    0);
    chk("arst_outdata",  bus.outdata,  0);
    chk("arst_outvs",    bus.outvs,    0);
    chk("arst_line_err", bus.line_err, 0);
    bus.inde  = 1'b0;
    bus.inwin = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    idle(4);

    for (int r = 0; r < 3; r++) begin
      fill_line(16'd7, 16'd0);
      run_line(W);
      chk($sformatf("post_rst_de_row%0d", r),
          bad_de + ((ncap != W) ? 1 : 0), 0);
      count_pass($sformatf("post_rst_pass_row%0d", r));
      idle(6);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
